// File: rtl/serv_bus_sched_pkg.sv
// Shared types for the SERV instruction/data bus scheduler.
package serv_bus_sched_pkg;

  // One-hot grant state
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_GNT_I = 3'b010,
    ST_GNT_D = 3'b100
  } state_t;

  typedef enum logic {
    SRC_IBUS = 1'b0,
    SRC_DBUS = 1'b1
  } req_src_t;

  localparam logic [3:0]  IBUS_SEL = 4'hF;
  localparam logic [31:0] IBUS_DAT = 32'h0;

  function automatic logic is_granted(input state_t s);
    return (s == ST_GNT_I) || (s == ST_GNT_D);
  endfunction

endpackage

// File: rtl/serv_bus_watchdog.sv
// Saturating grant-duration counter; o_max flags the all-ones terminal count.
module serv_bus_watchdog #(
  parameter int unsigned TIMEOUT_W      = 8,
  parameter              RESET_STRATEGY = "MINI"
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_max
);

  localparam bit RST_CNT = (RESET_STRATEGY != "NONE");

  logic [TIMEOUT_W-1:0] cnt;

  assign o_max = &cnt;

  always_ff @(posedge i_clk) begin
    if (RST_CNT && i_rst)
      cnt <= '0;
    else if (i_clr)
      cnt <= '0;
    else if (i_inc && !o_max)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/serv_bus_sched.sv
// Shares one Wishbone master between SERV ibus and dbus: one grant at a time,
// held until ack, with re-grant blocking and a watchdog abort.
module serv_bus_sched
  import serv_bus_sched_pkg::*;
#(
  parameter              RESET_STRATEGY = "MINI",
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_timeout,
  output logic        o_timeout_src,
  input  logic        i_timeout_clr
);

  localparam bit RST_SRC = (RESET_STRATEGY != "NONE");

  state_t     state;
  logic [1:0] wait_drop;
  req_src_t   timeout_src;
  logic       gnt_i;
  logic       gnt_d;
  logic       granted;
  logic       wd_max;
  logic       fire;
  logic       elig_i;
  logic       elig_d;
  logic       done;

  assign gnt_i   = (state == ST_GNT_I);
  assign gnt_d   = (state == ST_GNT_D);
  assign granted = is_granted(state);

  // Real ack has priority over a watchdog fire landing in the same cycle
  assign fire = granted & ~i_wb_ack & wd_max;

  assign elig_i = i_ibus_cyc & ~wait_drop[0];
  assign elig_d = i_dbus_cyc & ~wait_drop[1];

  assign done = i_wb_ack | fire |
                (gnt_i & ~i_ibus_cyc) | (gnt_d & ~i_dbus_cyc);

  if (TIMEOUT_W > 0) begin : g_wd
    serv_bus_watchdog #(
      .TIMEOUT_W      (TIMEOUT_W),
      .RESET_STRATEGY (RESET_STRATEGY)
    ) u_wd (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (~granted),
      .i_inc (granted & ~i_wb_ack),
      .o_max (wd_max)
    );
  end else begin : g_no_wd
    assign wd_max = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      wait_drop <= '0;
      o_timeout <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (elig_d)
            state <= ST_GNT_D;
          else if (elig_i)
            state <= ST_GNT_I;
        end
        ST_GNT_I, ST_GNT_D: begin
          if (done)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // SERV keeps dbus cyc high past its ack; hold it off until cyc drops
      wait_drop[0] <= i_ibus_cyc & (wait_drop[0] | o_ibus_ack);
      wait_drop[1] <= i_dbus_cyc & (wait_drop[1] | o_dbus_ack);

      if (fire)
        o_timeout <= 1'b1;
      else if (i_timeout_clr)
        o_timeout <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (RST_SRC && i_rst)
      timeout_src <= SRC_IBUS;
    else if (fire)
      timeout_src <= gnt_d ? SRC_DBUS : SRC_IBUS;
  end

  assign o_timeout_src = timeout_src;

  assign o_wb_cyc = granted;
  assign o_wb_adr = gnt_i ? i_ibus_adr : i_dbus_adr;
  assign o_wb_dat = gnt_i ? IBUS_DAT   : i_dbus_dat;
  assign o_wb_sel = gnt_i ? IBUS_SEL   : i_dbus_sel;
  assign o_wb_we  = gnt_i ? 1'b0       : i_dbus_we;

  assign o_ibus_ack = gnt_i & (i_wb_ack | fire);
  assign o_dbus_ack = gnt_d & (i_wb_ack | fire);
  assign o_ibus_rdt = fire ? '0 : i_wb_rdt;
  assign o_dbus_rdt = fire ? '0 : i_wb_rdt;

endmodule

// File: tb/tb_serv_bus_sched.sv
// Directed vector bench for serv_bus_sched (TIMEOUT_W=3 main DUT, default DUT for the long timeout).
module tb_serv_bus_sched;

  localparam logic [31:0] IADR = 32'h0000_0100;
  localparam logic [31:0] DADR = 32'h0000_0200;
  localparam logic [31:0] DDAT = 32'h1234_5678;
  localparam logic [3:0]  DSEL = 4'h3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ibus_adr, dbus_adr, dbus_dat, wb_rdt;
  logic        ibus_cyc, dbus_cyc, dbus_we, wb_ack, tclr;
  logic [3:0]  dbus_sel;

  logic [31:0] ibus_rdt, dbus_rdt, wb_adr, wb_dat;
  logic        ibus_ack, dbus_ack, wb_we, wb_cyc, tout, tsrc;
  logic [3:0]  wb_sel;

  logic [31:0] ibus_rdt8, dbus_rdt8, wb_adr8, wb_dat8;
  logic        ibus_ack8, dbus_ack8, wb_we8, wb_cyc8, tout8, tsrc8;
  logic [3:0]  wb_sel8;

  always #5 clk = ~clk;

  serv_bus_sched #(.TIMEOUT_W(3)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc), .o_ibus_rdt(ibus_rdt), .o_ibus_ack(ibus_ack),
    .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel), .i_dbus_we(dbus_we),
    .i_dbus_cyc(dbus_cyc), .o_dbus_rdt(dbus_rdt), .o_dbus_ack(dbus_ack),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel), .o_wb_we(wb_we), .o_wb_cyc(wb_cyc),
    .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack),
    .o_timeout(tout), .o_timeout_src(tsrc), .i_timeout_clr(tclr)
  );

  serv_bus_sched dut8 (
    .i_clk(clk), .i_rst(rst),
    .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc), .o_ibus_rdt(ibus_rdt8), .o_ibus_ack(ibus_ack8),
    .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel), .i_dbus_we(dbus_we),
    .i_dbus_cyc(dbus_cyc), .o_dbus_rdt(dbus_rdt8), .o_dbus_ack(dbus_ack8),
    .o_wb_adr(wb_adr8), .o_wb_dat(wb_dat8), .o_wb_sel(wb_sel8), .o_wb_we(wb_we8), .o_wb_cyc(wb_cyc8),
    .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack),
    .o_timeout(tout8), .o_timeout_src(tsrc8), .i_timeout_clr(tclr)
  );

  typedef struct {
    bit          icyc;
    bit          dcyc;
    bit          ack;
    logic [31:0] rdt;
    bit          clr;
    int          g;      // expected grant: 0 idle, 1 ibus, 2 dbus
    bit          eiack;
    bit          edack;
    logic [31:0] erdt;
    bit          etout;
    bit          etsrc;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic add(input bit ic, input bit dc, input bit ak, input logic [31:0] rd, input bit cl,
                     input int g, input bit ia, input bit da, input logic [31:0] erd,
                     input bit et, input bit es);
    vec_t v;
    v.icyc = ic; v.dcyc = dc; v.ack = ak; v.rdt = rd; v.clr = cl;
    v.g = g; v.eiack = ia; v.edack = da; v.erdt = erd; v.etout = et; v.etsrc = es;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ibus_cyc = 0; dbus_cyc = 0; wb_ack = 0; wb_rdt = '0; tclr = 0;
  endtask

  initial begin
    int k;
    rst = 1; ibus_adr = IADR; dbus_adr = DADR; dbus_dat = DDAT; dbus_sel = DSEL; dbus_we = 1;
    idle_inputs();

    // ic dc ak rdt clr | g ia da erdt tout tsrc
    add(0,0,0,0,0, 0,0,0,0,0,0);                          // reset state
    add(1,0,0,0,0, 0,0,0,0,0,0);                          // ibus request, adr 0x100
    add(1,0,0,0,0, 1,0,0,0,0,0);
    add(1,0,0,0,0, 1,0,0,0,0,0);
    add(1,0,1,32'hDEADBEEF,0, 1,1,0,32'hDEADBEEF,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    add(1,1,0,0,0, 0,0,0,0,0,0);                          // both request
    add(1,1,0,0,0, 2,0,0,0,0,0);
    add(1,1,1,32'hA5A50001,0, 2,0,1,32'hA5A50001,0,0);
    add(1,0,0,0,0, 0,0,0,0,0,0);
    add(1,0,0,0,0, 1,0,0,0,0,0);
    add(1,0,1,32'h11,0, 1,1,0,32'h11,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    add(0,1,0,0,0, 0,0,0,0,0,0);                          // dbus held after ack
    add(0,1,0,0,0, 2,0,0,0,0,0);
    add(0,1,1,32'h22,0, 2,0,1,32'h22,0,0);
    add(1,1,0,0,0, 0,0,0,0,0,0);
    add(1,1,0,0,0, 1,0,0,0,0,0);
    add(1,1,1,32'h33,0, 1,1,0,32'h33,0,0);
    add(0,1,0,0,0, 0,0,0,0,0,0);
    add(0,1,0,0,0, 0,0,0,0,0,0);
    add(0,1,0,0,0, 0,0,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    add(0,1,0,0,0, 0,0,0,0,0,0);
    add(0,1,0,0,0, 2,0,0,0,0,0);
    add(0,1,1,32'h44,0, 2,0,1,32'h44,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    add(0,1,0,0,0, 0,0,0,0,0,0);                          // dbus timeout
    for (int i = 0; i < 7; i++) add(0,1,0,0,0, 2,0,0,0,0,0);
    add(0,1,0,32'hBAD0BAD0,0, 2,0,1,32'h0,0,0);
    add(0,0,0,0,0, 0,0,0,0,1,1);
    add(0,0,0,0,1, 0,0,0,0,1,1);
    add(0,0,0,0,0, 0,0,0,0,0,1);
    add(0,1,0,0,0, 0,0,0,0,0,1);                          // ack on the fire count
    for (int i = 0; i < 7; i++) add(0,1,0,0,0, 2,0,0,0,0,1);
    add(0,1,1,32'h55,0, 2,0,1,32'h55,0,1);
    add(0,0,0,0,0, 0,0,0,0,0,1);
    add(1,0,0,0,0, 0,0,0,0,0,1);                          // ibus abandons mid-grant
    add(1,0,0,0,0, 1,0,0,0,0,1);
    add(0,0,0,0,0, 1,0,0,0,0,1);
    add(0,0,0,0,0, 0,0,0,0,0,1);

    tick();
    tick();
    foreach (vq[i]) begin
      vec_t v;
      v = vq[i];
      tick();
      rst = 0;
      ibus_cyc = v.icyc; dbus_cyc = v.dcyc; wb_ack = v.ack; wb_rdt = v.rdt; tclr = v.clr;
      #2;
      check($sformatf("r%0d.cyc", i),  {31'b0, wb_cyc},   {31'b0, v.g != 0});
      check($sformatf("r%0d.adr", i),  wb_adr,  (v.g == 1) ? IADR : DADR);
      check($sformatf("r%0d.we", i),   {31'b0, wb_we},    {31'b0, v.g != 1});
      check($sformatf("r%0d.sel", i),  {28'b0, wb_sel},   {28'b0, (v.g == 1) ? 4'hF : DSEL});
      check($sformatf("r%0d.dat", i),  wb_dat,  (v.g == 1) ? 32'h0 : DDAT);
      check($sformatf("r%0d.iack", i), {31'b0, ibus_ack}, {31'b0, v.eiack});
      check($sformatf("r%0d.dack", i), {31'b0, dbus_ack}, {31'b0, v.edack});
      check($sformatf("r%0d.irdt", i), ibus_rdt, v.erdt);
      check($sformatf("r%0d.drdt", i), dbus_rdt, v.erdt);
      check($sformatf("r%0d.tout", i), {31'b0, tout}, {31'b0, v.etout});
      check($sformatf("r%0d.tsrc", i), {31'b0, tsrc}, {31'b0, v.etsrc});
    end

    // Reset while in GNT_D with ibus blocked (wait_drop = 01)
    tick(); idle_inputs(); ibus_cyc = 1;
    tick(); wb_ack = 1; wb_rdt = 32'h66; #2;
    check("rst.pre_iack", {31'b0, ibus_ack}, 32'd1);
    tick(); wb_ack = 0; dbus_cyc = 1; #2;
    check("rst.pre_idle", {31'b0, wb_cyc}, 32'd0);
    tick(); rst = 1; #2;
    check("rst.in_gnt_d", {31'b0, wb_cyc}, 32'd1);
    check("rst.wd_before", {30'b0, dut.wait_drop}, 32'd1);
    check("rst.no_dack", {31'b0, dbus_ack}, 32'd0);
    tick(); rst = 0; #2;
    check("rst.cyc_low", {31'b0, wb_cyc}, 32'd0);
    check("rst.no_ack", {30'b0, ibus_ack, dbus_ack}, 32'd0);
    check("rst.wait_drop", {30'b0, dut.wait_drop}, 32'd0);
    check("rst.tsrc", {31'b0, tsrc}, 32'd0);
    tick(); #2;
    check("rst.regrant_d", {31'b0, wb_cyc}, 32'd1);
    check("rst.regrant_adr", wb_adr, DADR);
    tick(); idle_inputs();
    tick();

    // Default width watchdog: fire exactly 255 cycles after grant
    tick(); dbus_cyc = 1; #2;
    k = 0;
    while (!wb_cyc8 && k < 5) begin tick(); #2; k++; end
    check("w8.granted", {31'b0, wb_cyc8}, 32'd1);
    k = 0;
    while (!dbus_ack8 && k < 300) begin tick(); #2; k++; end
    check("w8.fire_cycle", k, 32'd255);
    check("w8.fire_rdt", dbus_rdt8, 32'h0);
    check("w8.flag_before", {31'b0, tout8}, 32'd0);
    tick(); dbus_cyc = 0; #2;
    check("w8.flag", {31'b0, tout8}, 32'd1);
    check("w8.src", {31'b0, tsrc8}, 32'd1);
    check("w8.cyc_low", {31'b0, wb_cyc8}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
